// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-entry register bank.
package reg_bank_pkg;

    // Bank controller states: normal operation or a one-entry-per-cycle clear sweep.
    typedef enum logic {
        IDLE,
        SWEEP
    } bank_state_t;

    // True when an accepted write should be forwarded to a read port this cycle.
    function automatic logic bypass_hit(input logic        enable,
                                        input logic        accept,
                                        input int unsigned wr_addr,
                                        input int unsigned rd_addr);
        return enable && accept && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/bank_entry.sv
// One storage word of the register bank; reset beats write, write beats clear.
module bank_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage word with async active-low reset, load, then synchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: one write port, two combinational read ports,
// optional write-to-read bypass and a multi-cycle clear sweep.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              wr_drop
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    bank_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q;
    logic              wr_accept;
    logic [WIDTH-1:0]  entry_q [DEPTH];

    assign wr_accept  = wr_en && (state_q == IDLE) && (32'(wr_addr) < DEPTH);
    assign busy       = (state_q == SWEEP);
    assign clear_done = (state_q == SWEEP) && (ptr_q == LAST);
    assign wr_drop    = wr_drop_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic en_i;
        logic clear_i;

        assign en_i    = wr_accept && (wr_addr == ADDR_W'(i));
        assign clear_i = (state_q == SWEEP) && (ptr_q == ADDR_W'(i));

        bank_entry #(
            .WIDTH(WIDTH)
        ) u_entry (
            .clock(clock),
            .reset(reset),
            .en   (en_i),
            .clear(clear_i),
            .d    (wr_data),
            .q    (entry_q[i])
        );
    end

    // Read muxes: out-of-range addresses read zero, bypass overrides stored data.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (32'(rd_addr_a) < DEPTH) begin
            rd_data_a = entry_q[rd_addr_a];
        end
        if (32'(rd_addr_b) < DEPTH) begin
            rd_data_b = entry_q[rd_addr_b];
        end
        if (bypass_hit(BYPASS != 0, wr_accept, 32'(wr_addr), 32'(rd_addr_a))) begin
            rd_data_a = wr_data;
        end
        if (bypass_hit(BYPASS != 0, wr_accept, 32'(wr_addr), 32'(rd_addr_b))) begin
            rd_data_b = wr_data;
        end
    end

    // Sweep FSM next state; terminates on compare with the last index, never on wrap.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM state, sweep pointer and the registered write-drop pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_en && !wr_accept;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: default build, no-bypass build
// and a non-power-of-two depth build, all sharing one stimulus stream.
module tb_reg_bank;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          clear_req;

    logic [W-1:0] a_rd_a, a_rd_b, n_rd_a, n_rd_b, f_rd_a, f_rd_b;
    logic         a_busy, a_done, a_drop;
    logic         n_busy, n_done, n_drop;
    logic         f_busy, f_done, f_drop;

    always #5 clock = ~clock;

    reg_bank #(.WIDTH(W), .DEPTH(8), .BYPASS(1)) u_dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(a_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(a_rd_b),
        .clear_req(clear_req), .busy(a_busy), .clear_done(a_done), .wr_drop(a_drop)
    );

    reg_bank #(.WIDTH(W), .DEPTH(8), .BYPASS(0)) u_nobyp (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(n_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(n_rd_b),
        .clear_req(clear_req), .busy(n_busy), .clear_done(n_done), .wr_drop(n_drop)
    );

    reg_bank #(.WIDTH(W), .DEPTH(5), .BYPASS(1)) u_d5 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(f_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(f_rd_b),
        .clear_req(clear_req), .busy(f_busy), .clear_done(f_done), .wr_drop(f_drop)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       checks = 0;
    int       errors = 0;

    task automatic push(input string tag, input logic [W-1:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check(input logic [W-1:0] obs);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Count busy cycles of the depth-5 build for one sweep started by a clear_req pulse.
    task automatic measure_d5(input string tag);
        int n      = 0;
        int done_at = -1;
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (f_busy) begin
                n++;
                if (f_done) done_at = n;
            end else if (n > 0) begin
                break;
            end
            cyc();
        end
        push({tag, "_busy_cycles"}, W'(5));
        check(W'(n));
        push({tag, "_done_cycle"}, W'(5));
        check(W'(done_at));
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; clear_req = 1'b0;

        // Reset state.
        cyc(); cyc(); #1;
        push("rst_busy", '0);  check(W'(a_busy));
        push("rst_done", '0);  check(W'(a_done));
        push("rst_drop", '0);  check(W'(a_drop));
        push("rst_rd_a", '0);  check(a_rd_a);

        cyc(); reset = 1'b1;

        // Basic write then read on both ports.
        cyc(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        cyc(); wr_addr = 3'd5; wr_data = 16'hBEEF;
        cyc(); wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        push("rd_a_addr3", 16'h1234); push("rd_b_addr5", 16'hBEEF);
        #1; check(a_rd_a); check(a_rd_b);
        // Asynchronous reset mid-cycle.
        reset = 1'b0;
        push("async_rst_a", '0); push("async_rst_b", '0);
        #1; check(a_rd_a); check(a_rd_b);
        cyc(); reset = 1'b1;

        // Bypass on vs off.
        cyc(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5; rd_addr_a = 3'd2;
        push("bypass_on", 16'hA5A5); push("bypass_off", 16'h0000);
        #1; check(a_rd_a); check(n_rd_a);
        cyc(); wr_en = 1'b0;
        push("nobyp_stored", 16'hA5A5);
        #1; check(n_rd_a);

        // Fill all entries, then sweep with a dropped write and an ignored clear_req.
        for (int i = 0; i < 8; i++) begin
            cyc(); wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'h00FF;
        end
        cyc(); wr_en = 1'b0; clear_req = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd0;
        push("busy_before_sweep", '0);
        #1; check(W'(a_busy));
        cyc(); clear_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr_en     = (k == 2);
            wr_addr   = 3'd6;
            wr_data   = 16'h7777;
            clear_req = (k == 4);
            push($sformatf("sweep%0d_busy", k), 16'h1);
            push($sformatf("sweep%0d_done", k), W'(k == 7));
            push($sformatf("sweep%0d_entry7", k), 16'h00FF);
            push($sformatf("sweep%0d_entry0", k), (k == 0) ? 16'h00FF : 16'h0000);
            #1; check(W'(a_busy)); check(W'(a_done)); check(a_rd_a); check(a_rd_b);
            if (k == 3) begin
                push("drop_during_sweep", 16'h1);
                check(W'(a_drop));
            end
            cyc();
        end
        wr_en = 1'b0; clear_req = 1'b0;
        push("busy_after_sweep", '0); push("done_after_sweep", '0);
        #1; check(W'(a_busy)); check(W'(a_done));
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = AW'(i);
            push($sformatf("cleared_entry%0d", i), '0);
            #1; check(a_rd_a);
        end

        // Same-cycle write and clear_req in IDLE.
        cyc(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h4444; clear_req = 1'b1;
        rd_addr_a = 3'd0;
        push("same_cycle_bypass", 16'h4444);
        #1; check(a_rd_a);
        cyc(); wr_en = 1'b0; clear_req = 1'b0;
        push("same_cycle_landed", 16'h4444); push("same_cycle_busy", 16'h1);
        #1; check(a_rd_a); check(W'(a_busy));
        cyc();
        push("same_cycle_cleared", '0);
        #1; check(a_rd_a);
        repeat (7) cyc();
        push("same_cycle_idle", '0);
        #1; check(W'(a_busy));

        // Depth-5 build: out-of-range write and read, sweep length, reset mid-sweep.
        cyc(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111; rd_addr_a = 3'd7;
        push("d5_read_oob", '0);
        #1; check(f_rd_a);
        cyc(); wr_en = 1'b0; rd_addr_a = 3'd6;
        push("d5_wr_drop", 16'h1); push("d5_oob_unchanged", '0);
        #1; check(W'(f_drop)); check(f_rd_a);
        repeat (10) cyc();
        measure_d5("d5_sweep");
        repeat (10) cyc();
        clear_req = 1'b1;
        cyc(); clear_req = 1'b0;
        cyc(); #1;
        reset = 1'b0;
        push("d5_rst_mid_busy", '0);
        #1; check(W'(f_busy));
        cyc(); reset = 1'b1;
        cyc();
        measure_d5("d5_fresh_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
